// File: rtl/mux_pkg.sv
// Shared constants and helpers for the channel arbiters and multiplexers.
package mux_pkg;

    // Arbitration mode encodings
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Index increment that wraps to 0 after n-1 (valid for any n, not just powers of two)
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker: round-robin starting at ptr, or fixed priority
// with the lowest index winning.
module rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any
);
    import mux_pkg::*;

    logic [CH_W-1:0] cand;

    // Scan candidates in priority order and grant the first requester found
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (mode == ARB_RR) begin
                cand = CH_W'((32'(ptr) + k) % NUM_CH);
            end else begin
                cand = CH_W'(k);
            end
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// NUM_CH-to-1 valid/ready multiplexer with round-robin or fixed-priority
// arbitration and a single registered output stage.
module rr_arb_mux #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_CH  = 4,
    parameter  int RR_MODE = 1,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);
    import mux_pkg::*;

    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0] gnt;
    logic              any;
    logic              load_en;
    logic              take;
    logic              mode;
    logic [WIDTH-1:0]  sel_data;

    assign mode = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req        (in_valid),
        .ptr        (ptr),
        .mode       (mode),
        .gnt_onehot (gnt),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // Handshake glue: accept a word when the output stage is empty or draining
    always_comb begin
        load_en  = !out_valid || out_ready;
        take     = load_en && any;
        in_ready = (load_en && rst_n) ? gnt : '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (gnt[k]) sel_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= gnt_idx;
                if (RR_MODE != 0) ptr <= CH_W'(wrap_inc(32'(gnt_idx), NUM_CH));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized
// traffic against a behavioural arbitration model.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: 4 channels, round-robin
    logic [3:0]  a_valid, a_ready;
    logic [31:0] a_data;
    logic        a_ordy, a_ov;
    logic [7:0]  a_od;
    logic [1:0]  a_och;
    // DUT B: 4 channels, fixed priority
    logic [3:0]  b_valid, b_ready;
    logic [31:0] b_data;
    logic        b_ordy, b_ov;
    logic [7:0]  b_od;
    logic [1:0]  b_och;
    // DUT C: 3 channels, round-robin
    logic [2:0]  c_valid, c_ready;
    logic [23:0] c_data;
    logic        c_ordy, c_ov;
    logic [7:0]  c_od;
    logic [1:0]  c_och;

    rr_arb_mux #(.WIDTH(8), .NUM_CH(4), .RR_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
        .out_valid(a_ov), .out_data(a_od), .out_ch(a_och), .out_ready(a_ordy));
    rr_arb_mux #(.WIDTH(8), .NUM_CH(4), .RR_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
        .out_valid(b_ov), .out_data(b_od), .out_ch(b_och), .out_ready(b_ordy));
    rr_arb_mux #(.WIDTH(8), .NUM_CH(3), .RR_MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
        .out_valid(c_ov), .out_data(c_od), .out_ch(c_och), .out_ready(c_ordy));

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_valid = '0; b_valid = '0; c_valid = '0;
        a_data = '0; b_data = '0; c_data = '0;
        a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference arbiter: first requester scanning from p (wrapping) or from 0
    function automatic int pick(input logic [3:0] v, input int n, input bit rr, input int p);
        for (int off = 0; off < n; off++) begin
            int c;
            c = rr ? (p + off) % n : off;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        a_valid = 4'b1111; b_valid = 4'b1111; c_valid = 3'b111;
        #2;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_ov got=%0b want=0", a_ov); end
        total++; if (a_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", a_ready); end
        total++; if (a_od !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", a_od); end
        total++; if (c_ready !== 3'b000) begin bad++; $display("FAIL reset_ready_c got=%b want=000", c_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        idle_all();
        a_valid = 4'b0001; a_data = 32'h0000_0011;
        #1;
        total++; if (a_ready !== 4'b0001) begin bad++; $display("FAIL first_ready got=%b want=0001", a_ready); end
        tick();
        total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL first_ov got=%0b want=1", a_ov); end
        total++; if (a_od !== 8'h11) begin bad++; $display("FAIL first_data got=%h want=11", a_od); end
        total++; if (a_och !== 2'd0) begin bad++; $display("FAIL first_ch got=%0d want=0", a_och); end
    endtask

    task automatic test_round_robin();
        do_reset();
        a_valid = 4'b1111; a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; a_ordy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] er;
            er = 4'b0001 << (k % 4);
            #1;
            total++; if (a_ready !== er) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, a_ready, er); end
            tick();
            total++; if (a_od !== 8'(8'hA0 + k % 4)) begin bad++; $display("FAIL rr_data[%0d] got=%h want=%h", k, a_od, 8'(8'hA0 + k % 4)); end
            total++; if (a_och !== 2'(k % 4)) begin bad++; $display("FAIL rr_ch[%0d] got=%0d want=%0d", k, a_och, k % 4); end
        end
    endtask

    task automatic test_fixed();
        do_reset();
        b_valid = 4'b1111; b_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; b_ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (b_och !== 2'd0 || b_od !== 8'hA0) begin bad++; $display("FAIL fixed_low[%0d] got=%0d/%h want=0/a0", k, b_och, b_od); end
        end
        b_valid = 4'b1100;
        #1;
        total++; if (b_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready got=%b want=0100", b_ready); end
        tick();
        total++; if (b_och !== 2'd2 || b_od !== 8'hA2) begin bad++; $display("FAIL fixed_hi got=%0d/%h want=2/a2", b_och, b_od); end
    endtask

    task automatic test_backpressure_and_drain();
        do_reset();
        a_valid = 4'b0001; a_data = 32'h0000_0055; a_ordy = 1'b1;
        tick();
        a_valid = 4'b1111; a_data = {8'hA3, 8'hA2, 8'hA1, 8'h55}; a_ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (a_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0000", k, a_ready); end
            tick();
            total++; if (a_ov !== 1'b1 || a_od !== 8'h55 || a_och !== 2'd0) begin bad++; $display("FAIL bp_hold[%0d] got=%0b/%h/%0d want=1/55/0", k, a_ov, a_od, a_och); end
        end
        a_ordy = 1'b1;
        #1;
        total++; if (a_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b want=0010", a_ready); end
        tick();
        total++; if (a_ov !== 1'b1 || a_od !== 8'hA1 || a_och !== 2'd1) begin bad++; $display("FAIL bp_refill got=%0b/%h/%0d want=1/a1/1", a_ov, a_od, a_och); end
        a_valid = 4'b0000;
        #1;
        total++; if (a_ready !== 4'b0000) begin bad++; $display("FAIL drain_ready got=%b want=0000", a_ready); end
        tick();
        total++; if (a_ov !== 1'b0 || a_och !== 2'd1) begin bad++; $display("FAIL drain got=%0b/%0d want=0/1", a_ov, a_och); end
    endtask

    task automatic test_nonpow2_wrap();
        logic [2:0] er [3];
        logic [1:0] ec [3];
        er = '{3'b100, 3'b001, 3'b100};
        ec = '{2'd2, 2'd0, 2'd2};
        do_reset();
        c_valid = 3'b010; c_data = {8'h32, 8'h31, 8'h30}; c_ordy = 1'b1;
        tick();
        c_valid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (c_ready !== er[k]) begin bad++; $display("FAIL wrap_ready[%0d] got=%b want=%b", k, c_ready, er[k]); end
            tick();
            total++; if (c_och !== ec[k]) begin bad++; $display("FAIL wrap_ch[%0d] got=%0d want=%0d", k, c_och, ec[k]); end
        end
        rst_n = 1'b0;
        #1;
        total++; if (c_ov !== 1'b0 || c_ready !== 3'b000) begin bad++; $display("FAIL midreset got=%0b/%b want=0/000", c_ov, c_ready); end
        tick();
        rst_n = 1'b1;
        c_valid = 3'b111;
        #1;
        total++; if (c_ready !== 3'b001) begin bad++; $display("FAIL post_reset_ready got=%b want=001", c_ready); end
        tick();
        total++; if (c_och !== 2'd0 || c_od !== 8'h30) begin bad++; $display("FAIL post_reset_out got=%0d/%h want=0/30", c_och, c_od); end
    endtask

    // Randomized traffic on one DUT (0=A, 1=B, 2=C) compared with the model
    task automatic test_random(input int which, input int cycles);
        int         n, g, m_ptr, m_ch;
        bit         rr, m_valid, load, r;
        logic [7:0] m_data, od;
        logic [3:0] v, rdy, er;
        logic [31:0] d;
        logic       ov;
        logic [1:0] och;
        n = (which == 2) ? 3 : 4;
        rr = (which != 1);
        do_reset();
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            v = 4'($urandom_range(0, 15));
            if (n == 3) v[3] = 1'b0;
            d = $urandom;
            r = ($urandom_range(0, 3) != 0);
            case (which)
                0: begin a_valid = v; a_data = d; a_ordy = r; end
                1: begin b_valid = v; b_data = d; b_ordy = r; end
                default: begin c_valid = v[2:0]; c_data = d[23:0]; c_ordy = r; end
            endcase
            #1;
            case (which)
                0: rdy = a_ready;
                1: rdy = b_ready;
                default: rdy = {1'b0, c_ready};
            endcase
            g = pick(v, n, rr, m_ptr);
            load = !m_valid || r;
            er = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
            total++; if (rdy !== er) begin bad++; $display("FAIL rand%0d_ready[%0d] got=%b want=%b", which, cyc, rdy, er); end
            tick();
            if (load && g >= 0) begin
                m_valid = 1'b1; m_data = d[g*8 +: 8]; m_ch = g;
                if (rr) m_ptr = (g + 1) % n;
            end else if (r) begin
                m_valid = 1'b0;
            end
            case (which)
                0: begin ov = a_ov; od = a_od; och = a_och; end
                1: begin ov = b_ov; od = b_od; och = b_och; end
                default: begin ov = c_ov; od = c_od; och = c_och; end
            endcase
            total++; if (ov !== m_valid) begin bad++; $display("FAIL rand%0d_ov[%0d] got=%0b want=%0b", which, cyc, ov, m_valid); end
            total++; if ($isunknown({od, och})) begin bad++; $display("FAIL rand%0d_x[%0d] got=%h/%b want=known", which, cyc, od, och); end
            if (m_valid) begin
                total++; if (od !== m_data || och !== 2'(m_ch)) begin bad++; $display("FAIL rand%0d_out[%0d] got=%h/%0d want=%h/%0d", which, cyc, od, och, m_data, m_ch); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed();
        test_backpressure_and_drain();
        test_nonpow2_wrap();
        test_random(0, 400);
        test_random(1, 400);
        test_random(2, 400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
